mod_enc_round_ctrl: RTL and testbench

//  Round sequencer for the AES-256 encryption datapath. Drives the state-register load and capture

---
 rtl/aes_ctrl_pkg.sv | 19 +
 rtl/mod_ctrl_timeout_cnt.sv | 38 +++
 rtl/mod_enc_round_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mod_enc_round_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-256 encryption round controller.
//   round_st_t : sequencer states
//   NR_AES256  : round count for a 256-bit key (15 round keys, 0..14)
//   RND_W      : width of the round / key-index buses
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KREQ,
        EXEC,
        OUT,
        ERR
    } round_st_t;

    localparam int NR_AES256 = 14;
    localparam int RND_W     = 4;

endpackage

// File: rtl/mod_ctrl_timeout_cnt.sv
// 8-bit wait counter used to bound the key-store handshake.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clr_i   : synchronous clear (wins over en_i)
//   en_i    : count enable
//   limit_i : number of counted cycles allowed
//   hit_o   : high while the counter sits on its last allowed value (limit_i-1)
module mod_ctrl_timeout_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       hit_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == (limit_i - 8'd1));

endmodule

// File: rtl/mod_enc_round_ctrl.sv
// Round sequencer for the AES-256 encryption datapath.
// Loads the plaintext, then for each round 0..NR fetches the round key via a
// req/ack handshake and runs ROUND_LAT datapath cycles, strobing st_en on the
// last one. The ciphertext is then presented with a valid/ready handshake.
//   clk, resetn          : clock; asynchronous active-high reset
//   start, abort         : block start (IDLE only) / cancel (any busy state)
//   ready_o              : controller idle
//   ld_state, st_en      : state-register load / capture strobes
//   sub_bypass, mix_bypass, round : datapath round controls
//   key_req, key_idx, key_ack     : key-store handshake
//   out_valid, out_rdy, done      : ciphertext handshake and completion pulse
//   err                  : sticky key-timeout flag
module mod_enc_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR        = NR_AES256,
    parameter int ROUND_LAT = 1,
    parameter int KEY_TO    = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    output logic             ready_o,
    output logic             ld_state,
    output logic             st_en,
    output logic             sub_bypass,
    output logic             mix_bypass,
    output logic [RND_W-1:0] round,
    output logic             key_req,
    output logic [RND_W-1:0] key_idx,
    input  logic             key_ack,
    output logic             out_valid,
    input  logic             out_rdy,
    output logic             done,
    output logic             err
);

    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);
    localparam logic [1:0]       LAT_LAST = 2'(ROUND_LAT - 1);
    localparam logic [7:0]       TO_LIM   = 8'(KEY_TO);

    round_st_t        state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [1:0]       lat_q, lat_d;
    logic             err_q, err_d;
    logic             to_clr, to_en, to_hit;
    logic             lat_last;
    logic             busy;

    assign lat_last = (lat_q == LAT_LAST);
    assign busy     = (state_q != IDLE);

    mod_ctrl_timeout_cnt u_to_cnt (
        .clk     (clk),
        .rst     (resetn),
        .clr_i   (to_clr),
        .en_i    (to_en),
        .limit_i (TO_LIM),
        .hit_o   (to_hit)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        lat_d   = lat_q;
        err_d   = err_q;
        to_clr  = 1'b1;
        to_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    round_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                state_d = KREQ;
            end
            KREQ: begin
                to_clr = key_ack;
                to_en  = 1'b1;
                if (key_ack) begin
                    state_d = EXEC;
                    lat_d   = '0;
                end else if (to_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            EXEC: begin
                if (lat_last) begin
                    lat_d = '0;
                    if (round_q == RND_LAST) begin
                        state_d = OUT;
                    end else begin
                        round_d = round_q + RND_W'(1);
                        state_d = KREQ;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            OUT: begin
                if (out_rdy) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            ERR: begin
                state_d = IDLE;
                round_d = '0;
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase

        // Abort overrides whatever the state decided, including a timeout
        // that would otherwise have set err on this cycle.
        if (abort && busy) begin
            state_d = IDLE;
            round_d = '0;
            lat_d   = '0;
            err_d   = err_q;
            to_clr  = 1'b1;
            to_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
            round_q <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    // Outputs come from registered state. abort is the one input allowed to
    // suppress them in the same cycle so an aborted block never emits a
    // capture, a key request or a ciphertext; done follows out_rdy directly.
    assign ready_o    = (state_q == IDLE);
    assign ld_state   = (state_q == LOAD);
    assign key_req    = (state_q == KREQ) && !abort;
    assign key_idx    = round_q;
    assign round      = round_q;
    assign st_en      = (state_q == EXEC) && lat_last && !abort;
    assign sub_bypass = (state_q == EXEC) && (round_q == '0);
    assign mix_bypass = (state_q == EXEC) && (round_q == RND_LAST);
    assign out_valid  = (state_q == OUT) && !abort;
    assign done       = out_valid && out_rdy;
    assign err        = err_q;

endmodule

// File: tb/tb_mod_enc_round_ctrl.sv
module tb_mod_enc_round_ctrl;

    localparam int NR  = 14;
    localparam int KTO = 15;
    localparam int S_IDLE = 0, S_LOAD = 1, S_KREQ = 2, S_EXEC = 3, S_OUT = 4, S_ERR = 5;

    typedef struct packed {
        logic       ready;
        logic       ld;
        logic       sten;
        logic       sub;
        logic       mix;
        logic [3:0] rnd;
        logic       kreq;
        logic [3:0] kidx;
        logic       ov;
        logic       done;
        logic       err;
    } outs_t;

    typedef struct {
        int dly;
        int exp_ov1;
        int exp_ov3;
    } vec_t;

    logic clk = 1'b0;
    logic resetn, start, abort;
    logic key_ack [2];
    logic out_rdy [2];
    logic w_ready [2], w_ld [2], w_sten [2], w_sub [2], w_mix [2];
    logic w_kreq [2], w_ov [2], w_done [2], w_err [2];
    logic [3:0] w_round [2], w_kidx [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mod_enc_round_ctrl #(.NR(NR), .ROUND_LAT(g == 0 ? 1 : 3), .KEY_TO(KTO)) dut (
            .clk(clk), .resetn(resetn), .start(start), .abort(abort),
            .ready_o(w_ready[g]), .ld_state(w_ld[g]), .st_en(w_sten[g]),
            .sub_bypass(w_sub[g]), .mix_bypass(w_mix[g]), .round(w_round[g]),
            .key_req(w_kreq[g]), .key_idx(w_kidx[g]), .key_ack(key_ack[g]),
            .out_valid(w_ov[g]), .out_rdy(out_rdy[g]), .done(w_done[g]), .err(w_err[g])
        );
    end

    // Reference model: where each controller is within its block.
    int m_st [2], m_rnd [2], m_wait [2], m_lat [2];
    bit m_err [2];
    int lat_of [2] = '{1, 3};

    // Stimulus controls
    bit drv_rst = 1, drv_start = 0, drv_abort = 0, drv_rdy = 1, rnd_ack = 0, rnd_rdy = 0;
    int ack_dly = 0, ack_block_idx = -1;

    // Statistics
    int errors = 0, checks = 0, cyc = 0, c0 = 0;
    int sten_cnt [2], done_cnt [2], ov_cnt [2], first_ov [2], first_ld [2];
    int last_sten_cyc [2], gap_min [2], gap_max [2], idx_bad [2], last_req_idx [2], kreq5_cnt [2];
    outs_t last_act [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic outs_t model_out(int d);
        outs_t o;
        o = '0;
        o.ready = (m_st[d] == S_IDLE);
        o.ld    = (m_st[d] == S_LOAD);
        o.kreq  = (m_st[d] == S_KREQ) && !abort;
        o.sten  = (m_st[d] == S_EXEC) && (m_lat[d] == lat_of[d] - 1) && !abort;
        o.sub   = (m_st[d] == S_EXEC) && (m_rnd[d] == 0);
        o.mix   = (m_st[d] == S_EXEC) && (m_rnd[d] == NR);
        o.rnd   = 4'(m_rnd[d]);
        o.kidx  = 4'(m_rnd[d]);
        o.ov    = (m_st[d] == S_OUT) && !abort;
        o.done  = o.ov && out_rdy[d];
        o.err   = m_err[d];
        return o;
    endfunction

    task automatic model_reset(input int d);
        m_st[d] = S_IDLE; m_rnd[d] = 0; m_wait[d] = 0; m_lat[d] = 0; m_err[d] = 0;
    endtask

    task automatic model_step(input int d);
        if (m_st[d] != S_IDLE && abort) begin
            m_st[d] = S_IDLE; m_rnd[d] = 0;
        end else begin
            case (m_st[d])
                S_IDLE: if (start && !abort) begin m_st[d] = S_LOAD; m_rnd[d] = 0; m_err[d] = 0; end
                S_LOAD: begin m_st[d] = S_KREQ; m_wait[d] = 0; end
                S_KREQ: begin
                    if (key_ack[d]) begin m_st[d] = S_EXEC; m_lat[d] = 0; end
                    else if (m_wait[d] == KTO - 1) begin m_st[d] = S_ERR; m_err[d] = 1; end
                    else m_wait[d]++;
                end
                S_EXEC: begin
                    if (m_lat[d] == lat_of[d] - 1) begin
                        if (m_rnd[d] == NR) m_st[d] = S_OUT;
                        else begin m_rnd[d]++; m_st[d] = S_KREQ; m_wait[d] = 0; end
                    end else m_lat[d]++;
                end
                S_OUT: if (out_rdy[d]) begin m_st[d] = S_IDLE; m_rnd[d] = 0; end
                default: begin m_st[d] = S_IDLE; m_rnd[d] = 0; end
            endcase
        end
    endtask

    function automatic logic ack_pick(int d);
        if (m_st[d] != S_KREQ) return 1'b0;
        if (m_rnd[d] == ack_block_idx) return 1'b0;
        if (rnd_ack) return ($urandom_range(0, 2) == 0);
        return (m_wait[d] >= ack_dly);
    endfunction

    function automatic outs_t act_of(int d);
        outs_t a;
        a.ready = w_ready[d]; a.ld = w_ld[d]; a.sten = w_sten[d]; a.sub = w_sub[d];
        a.mix = w_mix[d]; a.rnd = w_round[d]; a.kreq = w_kreq[d]; a.kidx = w_kidx[d];
        a.ov = w_ov[d]; a.done = w_done[d]; a.err = w_err[d];
        return a;
    endfunction

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            sten_cnt[d] = 0; done_cnt[d] = 0; ov_cnt[d] = 0; first_ov[d] = -1; first_ld[d] = -1;
            last_sten_cyc[d] = -1; gap_min[d] = 1000; gap_max[d] = 0; idx_bad[d] = 0;
            last_req_idx[d] = -1; kreq5_cnt[d] = 0;
        end
        c0 = cyc;
    endtask

    task automatic tick();
        outs_t a, e;
        @(negedge clk);
        resetn = drv_rst; start = drv_start; abort = drv_abort;
        for (int d = 0; d < 2; d++) begin
            out_rdy[d] = rnd_rdy ? 1'($urandom_range(0, 1)) : drv_rdy;
            key_ack[d] = ack_pick(d);
        end
        if (drv_rst) for (int d = 0; d < 2; d++) model_reset(d);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            a = act_of(d);
            e = model_out(d);
            chk($sformatf("d%0d cyc%0d outputs", d, cyc), 32'(a), 32'(e));
            if (a.sten) begin
                if (last_sten_cyc[d] >= 0) begin
                    if (cyc - last_sten_cyc[d] < gap_min[d]) gap_min[d] = cyc - last_sten_cyc[d];
                    if (cyc - last_sten_cyc[d] > gap_max[d]) gap_max[d] = cyc - last_sten_cyc[d];
                end
                last_sten_cyc[d] = cyc;
                sten_cnt[d]++;
            end
            if (a.kreq && int'(a.kidx) != last_req_idx[d]) begin
                if (int'(a.kidx) != last_req_idx[d] + 1) idx_bad[d]++;
                last_req_idx[d] = int'(a.kidx);
            end
            if (a.kreq && a.kidx == 4'd5) kreq5_cnt[d]++;
            if (a.ov) ov_cnt[d]++;
            if (a.ov && first_ov[d] < 0) first_ov[d] = cyc - c0;
            if (a.ld && first_ld[d] < 0) first_ld[d] = cyc - c0;
            if (a.done) done_cnt[d]++;
            last_act[d] = a;
        end
        if (!drv_rst) for (int d = 0; d < 2; d++) model_step(d);
    endtask

    task automatic do_reset();
        outs_t rv;
        rv = '0;
        rv.ready = 1'b1;
        drv_rst = 1; drv_start = 0; drv_abort = 0;
        tick(); tick();
        chk("reset state d0", 32'(last_act[0]), 32'(rv));
        chk("reset state d1", 32'(last_act[1]), 32'(rv));
        drv_rst = 0;
        tick();
    endtask

    task automatic pulse_start();
        drv_start = 1; tick(); drv_start = 0;
        c0 = cyc;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < budget) begin tick(); n++; end
        chk("completion within budget", 32'(n < budget), 32'd1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        vec_t vt [3];
        outs_t rv;
        int n, cnt;
        vt[0] = '{0, 32, 62};
        vt[1] = '{3, 77, 107};
        vt[2] = '{1, 47, 77};
        resetn = 1; start = 0; abort = 0;
        key_ack[0] = 0; key_ack[1] = 0; out_rdy[0] = 1; out_rdy[1] = 1;

        // Full blocks with fixed key-ack delays
        for (int i = 0; i < 3; i++) begin
            do_reset();
            ack_dly = vt[i].dly; drv_rdy = 1;
            clr_stats();
            pulse_start();
            run_until_done(400);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("v%0d d%0d ld_state cycle", i, d), 32'(first_ld[d]), 32'd1);
                chk($sformatf("v%0d d%0d st_en count", i, d), 32'(sten_cnt[d]), 32'd15);
                chk($sformatf("v%0d d%0d key_idx order", i, d), 32'(idx_bad[d]), 32'd0);
                chk($sformatf("v%0d d%0d last key_idx", i, d), 32'(last_req_idx[d]), 32'd14);
                chk($sformatf("v%0d d%0d done count", i, d), 32'(done_cnt[d]), 32'd1);
            end
            chk($sformatf("v%0d d0 out_valid cycle", i), 32'(first_ov[0]), 32'(vt[i].exp_ov1));
            chk($sformatf("v%0d d1 out_valid cycle", i), 32'(first_ov[1]), 32'(vt[i].exp_ov3));
        end

        // Key timeout on key 5, then a clean restart
        do_reset();
        ack_dly = 0; ack_block_idx = 5;
        clr_stats();
        pulse_start();
        n = 0;
        while (!(m_st[0] == S_IDLE && m_st[1] == S_IDLE && m_err[0] && m_err[1]) && n < 400) begin tick(); n++; end
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("timeout d%0d err sticky", d), 32'(last_act[d].err), 32'd1);
            chk($sformatf("timeout d%0d key_req cycles", d), 32'(kreq5_cnt[d]), 32'd15);
            chk($sformatf("timeout d%0d no done", d), 32'(done_cnt[d]), 32'd0);
            chk($sformatf("timeout d%0d st_en count", d), 32'(sten_cnt[d]), 32'd5);
        end
        ack_block_idx = -1;
        clr_stats();
        pulse_start();
        tick();
        chk("restart clears err d0", 32'(last_act[0].err), 32'd0);
        run_until_done(400);
        chk("restart d1 st_en count", 32'(sten_cnt[1]), 32'd15);

        // Abort on the first EXEC cycle of round 7
        do_reset();
        clr_stats();
        pulse_start();
        n = 0;
        while (n < 300) begin
            drv_abort = (m_st[0] == S_EXEC && m_rnd[0] == 7 && m_lat[0] == 0);
            tick(); n++;
            if (drv_abort) break;
        end
        drv_abort = 0;
        chk("abort cycle st_en", 32'(last_act[0].sten), 32'd0);
        chk("abort cycle round", 32'(last_act[0].rnd), 32'd7);
        tick();
        chk("abort then ready", 32'(last_act[0].ready), 32'd1);
        tick(); tick();
        chk("abort st_en count", 32'(sten_cnt[0]), 32'd7);
        chk("abort no out_valid", 32'(ov_cnt[0] + ov_cnt[1]), 32'd0);
        chk("abort no done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
        clr_stats();
        pulse_start();
        run_until_done(400);
        chk("after abort st_en d0", 32'(sten_cnt[0]), 32'd15);
        chk("after abort st_en d1", 32'(sten_cnt[1]), 32'd15);

        // Output stall with ignored start pulses
        do_reset();
        drv_rdy = 0;
        clr_stats();
        pulse_start();
        n = 0;
        while (m_st[0] != S_OUT && n < 200) begin tick(); n++; end
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            drv_start = (k % 3 == 0);
            tick();
            if (last_act[0].ov) cnt++;
        end
        drv_start = 0;
        chk("stall out_valid held", 32'(cnt), 32'd10);
        chk("stall no done", 32'(done_cnt[0]), 32'd0);
        drv_rdy = 1;
        tick();
        chk("stall release done", 32'(last_act[0].done), 32'd1);
        tick();
        chk("done single cycle", 32'(last_act[0].done), 32'd0);
        chk("stall back to idle", 32'(last_act[0].ready), 32'd1);
        run_until_done(400);
        chk("stall single done d0", 32'(done_cnt[0]), 32'd1);
        chk("stall d1 st_en count", 32'(sten_cnt[1]), 32'd15);

        // Reset during round 9 of the 3-cycle controller
        do_reset();
        clr_stats();
        pulse_start();
        n = 0;
        while (!(m_st[1] == S_EXEC && m_rnd[1] == 9) && n < 300) begin tick(); n++; end
        rv = '0; rv.ready = 1'b1;
        drv_rst = 1;
        tick();
        chk("mid-run reset d1 outputs", 32'(last_act[1]), 32'(rv));
        drv_rst = 0;
        tick();
        chk("mid-run reset no done d1", 32'(done_cnt[1]), 32'd0);
        clr_stats();
        pulse_start();
        run_until_done(400);
        chk("rerun d1 st_en count", 32'(sten_cnt[1]), 32'd15);
        chk("rerun d1 min spacing", 32'(gap_min[1]), 32'd4);
        chk("rerun d1 max spacing", 32'(gap_max[1]), 32'd4);

        // Random traffic against the model
        do_reset();
        rnd_ack = 1; rnd_rdy = 1;
        for (int k = 0; k < 3000; k++) begin
            drv_start = ($urandom_range(0, 3) == 0);
            drv_abort = ($urandom_range(0, 40) == 0);
            drv_rst   = ($urandom_range(0, 400) == 0);
            tick();
        end
        drv_start = 0; drv_abort = 0; drv_rst = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
